// File: rtl/data_mem_if.sv
// Per-thread data memory request/response bundle between compute-core LSUs
// (master) and the data memory responder (slave).
//
// Handshake: a request channel raises read_valid and/or write_valid with its
// address (and write data) and holds them until the matching ready bit is
// seen high. Ready is a single-cycle completion pulse, and read_data for that
// channel is valid in the same cycle. The master should drop valid in the
// ready cycle or the cycle after it. Request fields are sampled only at the
// grant edge, so later changes do not affect an access already in progress.
interface data_mem_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int THREADS   = 4
);
  logic [THREADS-1:0]                read_valid;
  logic [THREADS-1:0][ADDR_BITS-1:0] read_address;
  logic [THREADS-1:0]                read_ready;
  logic [THREADS-1:0][DATA_BITS-1:0] read_data;
  logic [THREADS-1:0]                write_valid;
  logic [THREADS-1:0][ADDR_BITS-1:0] write_address;
  logic [THREADS-1:0][DATA_BITS-1:0] write_data;
  logic [THREADS-1:0]                write_ready;
  // Responder FSM state, exposed for observation (IDLE=0, ACCESS=1, RESPOND=2).
  logic [1:0]                        fsm_state;

  modport master (
    output read_valid, read_address, write_valid, write_address, write_data,
    input  read_ready, read_data, write_ready, fsm_state
  );

  modport slave (
    input  read_valid, read_address, write_valid, write_address, write_data,
    output read_ready, read_data, write_ready, fsm_state
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: round-robin arbitration over per-thread read/write
// channels in front of a single-port RAM. It serves one access at a time,
// with a fixed grant-to-ready latency, and returns a one-cycle ready pulse.
module data_mem_responder #(
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8,
  parameter int THREADS_PER_BLOCK  = 4,
  parameter int LATENCY            = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  mem,
  output logic       busy
);

  localparam int A     = DATA_MEM_ADDR_BITS;
  localparam int D     = DATA_MEM_DATA_BITS;
  localparam int T     = THREADS_PER_BLOCK;
  localparam int DEPTH = 1 << A;
  localparam int PTR_W = (T > 1) ? $clog2(T) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Arbitration state
  logic [PTR_W-1:0] rr_ptr;
  logic [T-1:0]     cooldown;
  logic [T-1:0]     eligible;
  logic             grant_found;
  logic [PTR_W-1:0] grant_ch;
  logic [PTR_W-1:0] ptr_next;

  // Captured access
  logic [PTR_W-1:0] ch_q;
  logic             op_write_q;
  logic [A-1:0]     addr_q;
  logic [D-1:0]     wdata_q;
  logic [3:0]       cnt;
  logic             access_done;

  // Response registers
  logic [T-1:0]        rd_ready_q;
  logic [T-1:0]        wr_ready_q;
  logic [T-1:0][D-1:0] rd_data_q;

  logic [D-1:0] ram [DEPTH];

  // A channel that was just served sits out exactly one IDLE cycle. This way a
  // core that drops valid one cycle late is never served twice.
  assign eligible    = (mem.read_valid | mem.write_valid) & ~cooldown;
  assign access_done = (state == ACCESS) && (cnt == 4'd0);
  assign ptr_next    = (ch_q == PTR_W'(T - 1)) ? '0 : ch_q + 1'b1;

  // Round-robin scan: first eligible channel starting at rr_ptr, wrapping mod T.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] cand;
    grant_found = 1'b0;
    grant_ch    = '0;
    idx         = 0;
    cand        = '0;
    for (int i = 0; i < T; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= T) idx = idx - T;
      cand = PTR_W'(idx);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  // Next-state logic for the IDLE -> ACCESS -> RESPOND -> IDLE cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_found) next_state = ACCESS;
      ACCESS:  if (cnt == 4'd0) next_state = RESPOND;
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Capture the winning request at the grant edge, then count down the latency.
  // A channel with both valids is served as a read first. Its write is granted
  // on a later pass.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_q       <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            ch_q       <= grant_ch;
            op_write_q <= ~mem.read_valid[grant_ch];
            addr_q     <= mem.read_valid[grant_ch] ? mem.read_address[grant_ch]
                                                   : mem.write_address[grant_ch];
            wdata_q    <= mem.write_data[grant_ch];
            cnt        <= 4'(LATENCY - 1);
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Response pulses, read data, round-robin pointer and cooldown mask.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q  <= '0;
      rr_ptr     <= '0;
      cooldown   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cooldown <= '0;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (op_write_q) begin
              wr_ready_q[ch_q] <= 1'b1;
            end else begin
              rd_ready_q[ch_q] <= 1'b1;
              rd_data_q[ch_q]  <= ram[addr_q];
            end
          end
        end
        RESPOND: begin
          rd_ready_q <= '0;
          wr_ready_q <= '0;
          rr_ptr     <= ptr_next;
          cooldown   <= T'(1) << ch_q;
        end
        default: ;
      endcase
    end
  end

  // Single-port RAM: cleared on reset and written at the completing edge of a write.
  // Reset wins over a write in flight, so an interrupted write never lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ram[A'(i)] <= '0;
    end else if (access_done && op_write_q) begin
      ram[addr_q] <= wdata_q;
    end
  end

  assign mem.read_ready  = rd_ready_q;
  assign mem.write_ready = wr_ready_q;
  assign mem.read_data   = rd_data_q;
  assign mem.fsm_state   = state;
  assign busy            = (state == ACCESS) || (state == RESPOND);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Expected responses (op, channel, data)
// are queued when a request is driven and popped when a ready pulse appears.
module tb_data_mem_responder;

  localparam int A = 8;
  localparam int D = 8;
  localparam int T = 4;
  localparam int L = 2;
  localparam int W = 1 + 2 + D;

  logic clk;
  logic reset;
  logic busy;

  data_mem_if #(.ADDR_BITS(A), .DATA_BITS(D), .THREADS(T)) bus();

  data_mem_responder #(
    .DATA_MEM_ADDR_BITS(A),
    .DATA_MEM_DATA_BITS(D),
    .THREADS_PER_BLOCK(T),
    .LATENCY(L)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (bus.slave),
    .busy  (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // At most one ready bit may be high in any cycle.
  always @(negedge clk) begin
    check("ready_onehot", 32'($countones({bus.read_ready, bus.write_ready}) <= 1), 32'd1);
  end

  // Driver tasks (called at a negedge)
  task automatic drive_read(input int ch, input logic [A-1:0] addr, input logic [D-1:0] exp_data);
    logic [1:0] ci;
    ci = 2'(ch);
    bus.read_address[ci] = addr;
    bus.read_valid[ci]   = 1'b1;
    exp_q.push_back({1'b0, ci, exp_data});
  endtask

  task automatic drive_write(input int ch, input logic [A-1:0] addr, input logic [D-1:0] data);
    logic [1:0] ci;
    ci = 2'(ch);
    bus.write_address[ci] = addr;
    bus.write_data[ci]    = data;
    bus.write_valid[ci]   = 1'b1;
    exp_q.push_back({1'b1, ci, D'(0)});
  endtask

  // Wait for the next ready pulse and compare it against the scoreboard head.
  // lat = number of negedges waited; at_cyc = cycle count when the pulse was seen.
  task automatic wait_response(input string tag, input int max_cyc, input bit drop,
                               output int lat, output int at_cyc);
    int n;
    bit got;
    logic [W-1:0] obs;
    logic [W-1:0] expv;
    n = 0; got = 1'b0; obs = '1; lat = -1; at_cyc = -1;
    while (!got && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (|{bus.read_ready, bus.write_ready}) begin
        got = 1'b1;
        for (int c = 0; c < T; c++) begin
          logic [1:0] ci;
          ci = 2'(c);
          if (bus.read_ready[ci]) begin
            obs = {1'b0, ci, bus.read_data[ci]};
            if (drop) bus.read_valid[ci] = 1'b0;
          end else if (bus.write_ready[ci]) begin
            obs = {1'b1, ci, D'(0)};
            if (drop) bus.write_valid[ci] = 1'b0;
          end
        end
      end
    end
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check({tag, "_arrived"}, 32'(got), 32'd1);
    if (got) check(tag, 32'(obs), 32'(expv));
    lat = n;
    at_cyc = cyc;
  endtask

  task automatic expect_quiet(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      check(tag, 32'({bus.read_ready, bus.write_ready}), 32'd0);
    end
  endtask

  // Directed sequence
  initial begin
    int lat, c0, c1;
    int at[T];
    logic [D-1:0] pre[T];

    reset             = 1'b0;
    bus.read_valid    = '0;
    bus.write_valid   = '0;
    bus.read_address  = '0;
    bus.write_address = '0;
    bus.write_data    = '0;

    // 1: reset held with every valid high; nothing responds, RAM reads as zero
    @(negedge clk);
    bus.read_valid  = '1;
    bus.write_valid = '1;
    repeat (2) begin
      @(negedge clk);
      check("t1_ready_in_reset", 32'({bus.read_ready, bus.write_ready}), 32'd0);
      check("t1_busy_in_reset", 32'(busy), 32'd0);
    end
    bus.read_valid  = '0;
    bus.write_valid = '0;
    reset = 1'b1;
    drive_read(0, 8'h10, 8'h00);
    wait_response("t1_read_10", 20, 1'b1, lat, c0);

    // 2: write then read back, with the grant-to-ready latency checked
    repeat (3) @(negedge clk);
    drive_write(0, 8'h3C, 8'hA5);
    wait_response("t2_write", 20, 1'b1, lat, c0);
    check("t2_write_latency", 32'(lat), 32'(L + 1));
    repeat (3) @(negedge clk);
    drive_read(0, 8'h3C, 8'hA5);
    wait_response("t2_read", 20, 1'b1, lat, c0);
    check("t2_read_latency", 32'(lat), 32'(L + 1));
    @(negedge clk);
    check("t2_ready_fell", 32'(bus.read_ready), 32'd0);
    check("t2_data_hold", 32'(bus.read_data[0]), 32'hA5);

    // 3: preload one word per channel, then all four read together
    for (int i = 0; i < T; i++) begin
      pre[i] = D'($urandom_range(0, 255));
      drive_write(i, A'(8'h40 + i), pre[i]);
      wait_response("t3_preload", 20, 1'b1, lat, c0);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < T; i++) drive_read(i, A'(8'h40 + i), pre[i]);
    for (int i = 0; i < T; i++) begin
      wait_response("t3_read_rr", 20, 1'b1, lat, at[i]);
      if (i > 0) check("t3_grant_spacing", 32'(at[i] - at[i-1]), 32'(L + 2));
    end

    // 4: read and write together on ch2; the read is served first
    drive_write(2, 8'h05, 8'h11);
    wait_response("t4_preload", 20, 1'b1, lat, c0);
    repeat (3) @(negedge clk);
    drive_read(2, 8'h05, 8'h11);
    drive_write(2, 8'h05, 8'h77);
    wait_response("t4_read_first", 20, 1'b1, lat, c0);
    wait_response("t4_write_second", 20, 1'b1, lat, c0);
    repeat (2) @(negedge clk);
    drive_read(2, 8'h05, 8'h77);
    wait_response("t4_reread", 20, 1'b1, lat, c0);

    // 5: reset during ACCESS drops the write and its ready pulse
    repeat (2) @(negedge clk);
    bus.write_address[0] = 8'h20;
    bus.write_data[0]    = 8'h99;
    bus.write_valid[0]   = 1'b1;
    @(negedge clk);
    check("t5_busy_after_grant", 32'(busy), 32'd1);
    reset = 1'b0;
    bus.write_valid[0] = 1'b0;
    @(negedge clk);
    check("t5_busy_after_reset", 32'(busy), 32'd0);
    check("t5_ready_after_reset", 32'({bus.read_ready, bus.write_ready}), 32'd0);
    reset = 1'b1;
    expect_quiet("t5_no_pulse", 4);
    drive_read(1, 8'h20, 8'h00);
    wait_response("t5_ram_cleared", 20, 1'b1, lat, c0);

    // 6: ch1 holds valid one cycle past ready; cooldown lets pending ch3 in
    drive_write(1, 8'h60, 8'h33);
    wait_response("t6_preload1", 20, 1'b1, lat, c0);
    drive_write(3, 8'h61, 8'h44);
    wait_response("t6_preload3", 20, 1'b1, lat, c0);
    repeat (3) @(negedge clk);
    drive_read(1, 8'h60, 8'h33);
    wait_response("t6_ch1", 20, 1'b0, lat, c1);
    drive_read(3, 8'h61, 8'h44);
    @(negedge clk);
    @(negedge clk);
    bus.read_valid[1] = 1'b0;
    check("t6_ch3_granted", 32'(bus.fsm_state), 32'd1);
    wait_response("t6_ch3", 20, 1'b1, lat, c0);
    check("t6_ch3_spacing", 32'(c0 - c1), 32'(L + 2));
    expect_quiet("t6_no_double_serve", 8);

    // 6b: same hold with nobody else pending; the cooldown cycle grants nothing
    drive_read(1, 8'h60, 8'h33);
    wait_response("t6b_ch1", 20, 1'b0, lat, c1);
    @(negedge clk);
    @(negedge clk);
    check("t6b_no_regrant", 32'(busy), 32'd0);
    bus.read_valid[1] = 1'b0;
    expect_quiet("t6b_quiet", 8);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
